// File: rtl/note_player.sv
// Note playback stage: square-wave buzzer drive per accepted note, then a fixed silent gap.
// Optional macro NOTE_PLAYER_VOLUME_EN adds a 2-bit PWM volume input (note_vol).
module note_player #(
  parameter int unsigned PERIOD_W   = 17,
  parameter int unsigned DUR_W      = 26,
  parameter int unsigned GAP_CYCLES = 500000,
  parameter logic        BUZZ_IDLE  = 1'b1
) (
  input  logic                clk,
  input  logic                rb,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic [DUR_W-1:0]    note_dur,
  input  logic                note_rest,
`ifdef NOTE_PLAYER_VOLUME_EN
  input  logic [1:0]          note_vol,
`endif
  output logic                buzzer,
  output logic                busy,
  output logic                note_done
);

  localparam int unsigned    GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StTone, StGap} state_e;

  state_e              r_state, w_state_next;
  logic [PERIOD_W-1:0] r_period, w_period_next;
  logic [DUR_W-1:0]    r_dur, w_dur_next;
  logic                r_rest, w_rest_next;
  logic [DUR_W-1:0]    r_beat, w_beat_next;
  logic [PERIOD_W-1:0] r_tone, w_tone_next;
  logic [GAP_W-1:0]    r_gap, w_gap_next;
  logic                r_buzz, w_buzz_next;
  logic                r_done, w_done_next;
  logic                w_accept;
`ifdef NOTE_PLAYER_VOLUME_EN
  logic [1:0]          r_vol, w_vol_next;
  logic [1:0]          r_pwm, w_pwm_next;
`endif

  assign w_accept = note_valid && (r_state == StIdle);

  always_comb begin
    w_state_next  = r_state;
    w_period_next = r_period;
    w_dur_next    = r_dur;
    w_rest_next   = r_rest;
    w_beat_next   = r_beat;
    w_tone_next   = r_tone;
    w_gap_next    = r_gap;
    w_buzz_next   = r_buzz;
    w_done_next   = 1'b0;
`ifdef NOTE_PLAYER_VOLUME_EN
    w_vol_next    = r_vol;
    w_pwm_next    = w_accept ? 2'd0 : r_pwm + 2'd1;
    if (w_accept) w_vol_next = note_vol;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_period_next = note_period;
          w_dur_next    = note_dur;
          w_rest_next   = note_rest | (note_period == '0);
          w_beat_next   = '0;
          w_tone_next   = '0;
          w_buzz_next   = BUZZ_IDLE;
          if (note_dur == '0) w_done_next  = 1'b1;
          else                w_state_next = StTone;
        end
      end
      StTone: begin
        w_beat_next = r_beat + DUR_W'(1);
        if (!r_rest) begin
          if (r_tone == r_period - PERIOD_W'(1)) begin
            w_tone_next = '0;
            w_buzz_next = ~r_buzz;
          end else begin
            w_tone_next = r_tone + PERIOD_W'(1);
          end
        end
        // End of note overrides any toggle landing on the same edge.
        if (r_beat == r_dur - DUR_W'(1)) begin
          w_buzz_next = BUZZ_IDLE;
          w_gap_next  = '0;
          if (GAP_CYCLES == 0) begin
            w_state_next = StIdle;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = StGap;
          end
        end
      end
      StGap: begin
        if (r_gap == GAP_LAST) begin
          w_state_next = StIdle;
          w_done_next  = 1'b1;
        end else begin
          w_gap_next = r_gap + GAP_W'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rb) begin
    if (rb) begin
      r_state  <= StIdle;
      r_period <= '0;
      r_dur    <= '0;
      r_rest   <= 1'b0;
      r_beat   <= '0;
      r_tone   <= '0;
      r_gap    <= '0;
      r_buzz   <= BUZZ_IDLE;
      r_done   <= 1'b0;
`ifdef NOTE_PLAYER_VOLUME_EN
      r_vol    <= '0;
      r_pwm    <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_period <= w_period_next;
      r_dur    <= w_dur_next;
      r_rest   <= w_rest_next;
      r_beat   <= w_beat_next;
      r_tone   <= w_tone_next;
      r_gap    <= w_gap_next;
      r_buzz   <= w_buzz_next;
      r_done   <= w_done_next;
`ifdef NOTE_PLAYER_VOLUME_EN
      r_vol    <= w_vol_next;
      r_pwm    <= w_pwm_next;
`endif
    end
  end

  assign note_ready = (r_state == StIdle);
  assign busy       = (r_state != StIdle);
  assign note_done  = r_done;

`ifdef NOTE_PLAYER_VOLUME_EN
  // Active phase is gated by PWM; the internal square-wave phase keeps running.
  assign buzzer = ((r_state == StTone) && (r_buzz != BUZZ_IDLE) && (r_pwm > r_vol)) ?
                  BUZZ_IDLE : r_buzz;
`else
  assign buzzer = r_buzz;
`endif

endmodule

// File: tb/tb_note_player.sv
// Directed self-checking bench for note_player (GAP_CYCLES=4, BUZZ_IDLE=1).
module tb_note_player;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rb;
  logic        note_valid;
  logic        note_ready;
  logic [16:0] note_period;
  logic [25:0] note_dur;
  logic        note_rest;
  logic        buzzer;
  logic        busy;
  logic        note_done;
`ifdef NOTE_PLAYER_VOLUME_EN
  logic [1:0]  note_vol = 2'd3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  note_player #(
    .PERIOD_W  (17),
    .DUR_W     (26),
    .GAP_CYCLES(GAP),
    .BUZZ_IDLE (1'b1)
  ) dut (
    .clk        (clk),
    .rb         (rb),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_period(note_period),
    .note_dur   (note_dur),
    .note_rest  (note_rest),
`ifdef NOTE_PLAYER_VOLUME_EN
    .note_vol   (note_vol),
`endif
    .buzzer     (buzzer),
    .busy       (busy),
    .note_done  (note_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Expected levels k cycles after the accept edge (sampled just after edge E0+k).
  function automatic logic exp_buzz(input int p, input int d, input bit r, input int k);
    if (r || p == 0 || k >= d) return 1'b1;
    return ((k / p) % 2) == 0;
  endfunction

  function automatic logic exp_busy(input int d, input int k);
    return (d != 0) && (k < d + GAP);
  endfunction

  function automatic logic exp_done(input int d, input int k);
    return (d == 0) ? (k == 0) : (k == d + GAP);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string nm, input int p, input int d, input bit r, input int k);
    chk($sformatf("%s buzzer k=%0d", nm, k), buzzer, exp_buzz(p, d, r, k));
    chk($sformatf("%s busy k=%0d", nm, k), busy, exp_busy(d, k));
    chk($sformatf("%s ready k=%0d", nm, k), note_ready, !exp_busy(d, k));
    chk($sformatf("%s done k=%0d", nm, k), note_done, exp_done(d, k));
  endtask

  task automatic run_note(input string nm, input int p, input int d, input bit r);
    chk({nm, " ready before accept"}, note_ready, 1'b1);
    note_period = 17'(p);
    note_dur    = 26'(d);
    note_rest   = r;
    note_valid  = 1'b1;
    tick();
    note_valid  = 1'b0;
    for (int k = 0; k <= d + GAP + 2; k++) begin
      chk_cycle(nm, p, d, r, k);
      tick();
    end
  endtask

  initial begin
    rb          = 1'b1;
    note_valid  = 1'b0;
    note_period = '0;
    note_dur    = '0;
    note_rest   = 1'b0;
    #2;
    chk("reset buzzer (in reset)", buzzer, 1'b1);
    chk("reset ready (in reset)", note_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rb = 1'b0;
    chk("reset buzzer", buzzer, 1'b1);
    chk("reset ready", note_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset done", note_done, 1'b0);
    tick();

    run_note("tone", 3, 20, 1'b0);
    run_note("rest", 5, 10, 1'b1);
    run_note("per0", 0, 10, 1'b0);
    run_note("dur0", 7, 0, 1'b0);

    // Asynchronous abort mid-note.
    note_period = 17'd3;
    note_dur    = 26'd20;
    note_rest   = 1'b0;
    note_valid  = 1'b1;
    tick();
    note_valid  = 1'b0;
    repeat (4) tick();
    chk("abort pre buzzer", buzzer, 1'b0);
    repeat (3) tick();
    chk("abort pre busy", busy, 1'b1);
    chk("abort pre ready", note_ready, 1'b0);
    #2 rb = 1'b1;
    #1;
    chk("abort buzzer", buzzer, 1'b1);
    chk("abort ready", note_ready, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort done", note_done, 1'b0);
    repeat (2) tick();
    rb = 1'b0;
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("post-abort done k=%0d", k), note_done, 1'b0);
      chk($sformatf("post-abort busy k=%0d", k), busy, 1'b0);
      tick();
    end

    // Back-to-back: valid held, second note accepted in the done cycle.
    note_period = 17'd2;
    note_dur    = 26'd6;
    note_rest   = 1'b0;
    note_valid  = 1'b1;
    tick();
    for (int k = 0; k <= 23; k++) begin
      if (k == 11) note_valid = 1'b0;
      if (k <= 10) chk_cycle("b2b-1", 2, 6, 1'b0, k);
      else         chk_cycle("b2b-2", 2, 6, 1'b0, k - 11);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
